// File: rtl/clk_strobe_gen.sv
// clk_strobe_gen: per-channel clock-enable strobes and square waves derived from one board clock,
// with glitch-free runtime divisor updates and a global phase-aligning sync.
module clk_strobe_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 20,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_RST = {20'd10002, 20'd625002, 20'd4}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_sync,
  input  logic              i_wr,
  input  logic [3:0]        i_wr_ch,
  input  logic [CNT_W-1:0]  i_wr_div,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_sq,
  output logic [NUM_CH-1:0] o_pend,
  output logic              o_wr_err
);
  localparam logic [4:0] NCH = 5'(NUM_CH);
  logic wr_ok, wr_err_q, wr_err_d;
  assign wr_ok = i_wr && (i_wr_div != '0) && ({1'b0, i_wr_ch} < NCH);
  assign wr_err_d = i_wr && !wr_ok;
  assign o_wr_err = wr_err_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) wr_err_q <= 1'b0;
    else wr_err_q <= wr_err_d;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] div_q, div_d, pdiv_q, pdiv_d, cnt_q, cnt_d;
    logic [CNT_W:0] h;
    logic pend_q, pend_d, tick_q, tick_d, sq_q, sq_d, wr_k, tc, restart;
    assign wr_k = wr_ok && (i_wr_ch == 4'(g));
    assign tc = cnt_q == div_q - CNT_W'(1);
    // Extra bit keeps the half-period correct at the all-ones divisor
    assign h = ({1'b0, div_q} + (CNT_W+1)'(1)) >> 1;
    assign restart = i_sync || !i_en[g];
    always_comb begin
      div_d = div_q;
      pdiv_d = wr_k ? i_wr_div : pdiv_q;
      pend_d = pend_q;
      cnt_d = (restart || tc) ? '0 : cnt_q + CNT_W'(1);
      tick_d = !restart && tc;
      sq_d = !restart && ({1'b0, cnt_q} < h);
      if (restart) begin
        div_d = wr_k ? i_wr_div : pend_q ? pdiv_q : div_q;
        pend_d = 1'b0;
      end else if (wr_k) begin
        pend_d = 1'b1;
      end else if (tc && pend_q) begin
        div_d = pdiv_q;
        pend_d = 1'b0;
      end
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        div_q <= DIV_RST[g*CNT_W +: CNT_W];
        pdiv_q <= DIV_RST[g*CNT_W +: CNT_W];
        pend_q <= 1'b0;
        cnt_q <= '0;
        tick_q <= 1'b0;
        sq_q <= 1'b0;
      end else begin
        div_q <= div_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
        cnt_q <= cnt_d;
        tick_q <= tick_d;
        sq_q <= sq_d;
      end
    assign o_tick[g] = tick_q;
    assign o_sq[g] = sq_q;
    assign o_pend[g] = pend_q;
  end
endmodule

// File: tb/tb_clk_strobe_gen.sv
// tb_clk_strobe_gen: directed and random stimulus against a period-position reference model.
module tb_clk_strobe_gen;
  localparam int N = 3, W = 20;
  logic i_clk = 0, i_rst_n = 1, i_sync = 0, i_wr = 0;
  logic [N-1:0] i_en = '1;
  logic [3:0] i_wr_ch = 0;
  logic [W-1:0] i_wr_div = 0;
  logic [N-1:0] o_tick, o_sq, o_pend;
  logic o_wr_err;
  int errors = 0, checks = 0;
  int rst_div[N] = '{4, 625002, 10002};
  int d[N], pd[N], pos[N];
  bit pend[N];
  logic [N-1:0] e_tick, e_sq, e_pend;
  logic e_err;

  clk_strobe_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_sync(i_sync), .i_wr(i_wr),
    .i_wr_ch(i_wr_ch), .i_wr_div(i_wr_div), .o_tick(o_tick), .o_sq(o_sq),
    .o_pend(o_pend), .o_wr_err(o_wr_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    for (int k = 0; k < N; k++) begin
      d[k] = rst_div[k]; pd[k] = rst_div[k]; pos[k] = 0; pend[k] = 0;
    end
    e_tick = '0; e_sq = '0; e_err = 0;
  endtask

  // Model: pos is the index within the current period of the cycle the next edge completes.
  task automatic cyc;
    bit wok, wk;
    e_err = i_wr && (i_wr_div == 0 || i_wr_ch >= N);
    wok = i_wr && !e_err;
    for (int k = 0; k < N; k++) begin
      wk = wok && (i_wr_ch == k);
      if (i_sync || !i_en[k]) begin
        if (wk) begin d[k] = i_wr_div; pd[k] = i_wr_div; end
        else if (pend[k]) d[k] = pd[k];
        pend[k] = 0; pos[k] = 0; e_tick[k] = 0; e_sq[k] = 0;
      end else begin
        e_tick[k] = (pos[k] == d[k] - 1);
        e_sq[k] = (pos[k] < (d[k] + 1) / 2);
        pos[k] = (pos[k] + 1) % d[k];
        if (wk) begin pd[k] = i_wr_div; pend[k] = 1; end
        else if (e_tick[k] && pend[k]) begin d[k] = pd[k]; pend[k] = 0; end
      end
      e_pend[k] = pend[k];
    end
    @(posedge i_clk);
    #1;
    chk("tick", 32'(o_tick), 32'(e_tick));
    chk("sq", 32'(o_sq), 32'(e_sq));
    chk("pend", 32'(o_pend), 32'(e_pend));
    chk("wr_err", 32'(o_wr_err), 32'(e_err));
    i_wr = 0;
    i_sync = 0;
  endtask

  task automatic wr(input int ch, input int dv);
    i_wr = 1; i_wr_ch = 4'(ch); i_wr_div = W'(dv);
    cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tick"}, 32'(o_tick), 0);
    chk({tag, "_sq"}, 32'(o_sq), 0);
    chk({tag, "_pend"}, 32'(o_pend), 0);
    chk({tag, "_err"}, 32'(o_wr_err), 0);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (pos[0] != p && n < 50) begin cyc(); n++; end
    chk("wait_pos", 32'(pos[0]), 32'(p));
  endtask

  initial begin
    model_reset();
    #2 i_rst_n = 0;
    #10 chk_zero("reset");
    @(negedge i_clk) i_rst_n = 1;
    repeat (12) cyc();
    wr(0, 3);
    repeat (10) cyc();
    wr(0, 1);
    repeat (8) cyc();
    wr(0, 4);
    repeat (8) cyc();
    wait_pos(1);
    wr(0, 6);
    repeat (14) cyc();
    wait_pos(d[0] - 1);
    wr(0, 3);
    repeat (12) cyc();
    wr(0, 0);
    wr(3, 5);
    wr(15, 2);
    repeat (4) cyc();
    wr(0, 5);
    wr(2, 5);
    repeat (3) cyc();
    i_sync = 1;
    cyc();
    repeat (12) cyc();
    i_en[0] = 0;
    wr(0, 2);
    repeat (3) cyc();
    i_en[0] = 1;
    repeat (6) cyc();
    repeat (3000) begin
      i_en = ($urandom_range(0, 15) == 0) ? N'($urandom) : '1;
      i_sync = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) begin
        i_wr = 1; i_wr_ch = 4'($urandom_range(0, 4)); i_wr_div = W'($urandom_range(0, 9));
      end
      cyc();
    end
    i_en = '1;
    @(negedge i_clk) i_rst_n = 0;
    #1 chk_zero("reset2");
    model_reset();
    @(negedge i_clk) i_rst_n = 1;
    wr(0, 7);
    wait_pos(2);
    @(negedge i_clk) i_rst_n = 0;
    #1 chk_zero("reset_mid");
    model_reset();
    @(negedge i_clk) i_rst_n = 1;
    repeat (10010) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
